// File: rtl/cpu_pkg.sv
// Shared core definitions: opcodes, latency-class encodings and default unit latencies.
package cpu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SLT = 4'h5;
    localparam logic [3:0] OP_SLL = 4'h6;
    localparam logic [3:0] OP_SRL = 4'h7;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hA;
    localparam logic [3:0] OP_BNE = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;
    localparam logic [3:0] OP_DIV = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] LAT_ALU  = 2'd0;
    localparam logic [1:0] LAT_LOAD = 2'd1;
    localparam logic [1:0] LAT_LONG = 2'd2;

    localparam int unsigned DEF_ALU_LAT  = 0;
    localparam int unsigned DEF_LOAD_LAT = 1;
    localparam int unsigned DEF_LONG_LAT = 3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: cycles remaining until the pending write becomes forwardable.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    // busy tracks the next count so it stays a register, not a decode of cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                cnt  <= load_val;
                busy <= (load_val != '0);
            end else if (cnt != '0) begin
                cnt  <= cnt - CNT_W'(1);
                busy <= (cnt > CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard and interlock: RAW/WAW stall generation, per-register countdowns, stall counter.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_W    = $clog2(NUM_REGS),
    parameter int unsigned ALU_LAT  = DEF_ALU_LAT,
    parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
    parameter int unsigned LONG_LAT = DEF_LONG_LAT,
    parameter int unsigned PERF_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                id_rs_used,
    input  logic                id_rt_used,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                id_rd_we,
    input  logic [1:0]          id_lat_cls,
    input  logic                flush,
    input  logic                mem_stall,
    input  logic                perf_clr,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [PERF_W-1:0]   stall_cycles
);

    localparam int unsigned MAX_LAT = max3(ALU_LAT, LOAD_LAT, LONG_LAT);
    localparam int unsigned CNT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [CNT_W-1:0] new_lat_c;
    logic             raw_c;
    logic             waw_c;
    logic             issue_c;

    always_comb begin
        new_lat_c = CNT_W'(LONG_LAT);
        case (id_lat_cls)
            LAT_ALU:  new_lat_c = CNT_W'(ALU_LAT);
            LAT_LOAD: new_lat_c = CNT_W'(LOAD_LAT);
            default:  new_lat_c = CNT_W'(LONG_LAT);
        endcase
    end

    // Hazard checks see pre-update state, so a self-referencing instruction only sees the older writer
    assign raw_c = (id_rs_used && (id_rs != '0) && (cnt[id_rs] != '0)) ||
                   (id_rt_used && (id_rt != '0) && (cnt[id_rt] != '0));
    assign waw_c = id_rd_we && (id_rd != '0) && (cnt[id_rd] > new_lat_c);

    assign stall   = id_valid && !flush && (raw_c || waw_c);
    assign issue_c = id_valid && !flush && !mem_stall && !stall;

    assign cnt[0]       = '0;
    assign busy_mask[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .load     (issue_c && id_rd_we && (id_rd == REG_W'(i))),
            .load_val (new_lat_c),
            .hold     (mem_stall),
            .busy     (busy_mask[i]),
            .cnt      (cnt[i])
        );
    end

    // Interlock-cycle counter: frozen pipeline cycles are not interlock cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if (stall && !mem_stall && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: table-driven cycle vectors plus saturation and reset sequences.
module tb_hazard_scoreboard;

    localparam int unsigned PW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [3:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_rs_used = 1'b0, id_rt_used = 1'b0, id_rd_we = 1'b0;
    logic [1:0]  id_lat_cls = '0;
    logic        flush = 1'b0, mem_stall = 1'b0, perf_clr = 1'b0;
    logic        stall;
    logic [15:0] busy_mask;
    logic [PW-1:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard #(.PERF_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_rd        (id_rd),
        .id_rd_we     (id_rd_we),
        .id_lat_cls   (id_lat_cls),
        .flush        (flush),
        .mem_stall    (mem_stall),
        .perf_clr     (perf_clr),
        .stall        (stall),
        .busy_mask    (busy_mask),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, valid;
        logic [3:0]  rs;
        logic        rsu;
        logic [3:0]  rt;
        logic        rtu;
        logic [3:0]  rd;
        logic        we;
        logic [1:0]  cls;
        logic        fl, ms, clr;
        logic        es;
        logic [15:0] eb;
        logic [7:0]  esc;
    } vec_t;

    typedef struct {
        logic        es;
        logic [15:0] eb;
        logic [7:0]  esc;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];

    function automatic vec_t v(input logic r, input logic va, input logic [3:0] rs, input logic rsu,
                               input logic [3:0] rt, input logic rtu, input logic [3:0] rd,
                               input logic we, input logic [1:0] cls, input logic fl,
                               input logic ms, input logic clr, input logic es,
                               input logic [15:0] eb, input logic [7:0] esc);
        vec_t t;
        t.rst = r; t.valid = va; t.rs = rs; t.rsu = rsu; t.rt = rt; t.rtu = rtu;
        t.rd = rd; t.we = we; t.cls = cls; t.fl = fl; t.ms = ms; t.clr = clr;
        t.es = es; t.eb = eb; t.esc = esc;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; id_valid = t.valid; id_rs = t.rs; id_rs_used = t.rsu;
        id_rt = t.rt; id_rt_used = t.rtu; id_rd = t.rd; id_rd_we = t.we;
        id_lat_cls = t.cls; flush = t.fl; mem_stall = t.ms; perf_clr = t.clr;
    endtask

    task automatic apply(input int idx, input vec_t t);
        exp_t e;
        @(negedge clk);
        drive(t);
        expq.push_back('{t.es, t.eb, t.esc});
        #1;
        e = expq.pop_front();
        chk("stall", idx, 32'(stall), 32'(e.es));
        chk("busy_mask", idx, 32'(busy_mask), 32'(e.eb));
        chk("stall_cycles", idx, 32'(stall_cycles), 32'(e.esc));
    endtask

    initial begin
        vec_t idle;
        vec_t t;
        int   mcnt;
        int   sc_model;
        int   n_st;
        int   iters;

        // rst, valid, rs, rsu, rt, rtu, rd, we, cls, fl, ms, clr | stall, busy, stall_cycles
        vecs.push_back(v(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,16'h0000,0));
        vecs.push_back(v(0,1, 5,1, 0,0,  3,1,1, 0,0,0, 0,16'h0000,0));
        vecs.push_back(v(0,1, 3,1, 5,1,  4,1,0, 0,0,0, 1,16'h0008,0));
        vecs.push_back(v(0,1, 3,1, 5,1,  4,1,0, 0,0,0, 0,16'h0000,1));
        vecs.push_back(v(0,1, 4,1, 4,1,  5,1,0, 0,0,0, 0,16'h0000,1));
        vecs.push_back(v(0,1, 0,0, 0,0,  6,1,2, 0,0,0, 0,16'h0000,1));
        vecs.push_back(v(0,1, 6,1, 0,0,  7,1,0, 0,0,0, 1,16'h0040,1));
        vecs.push_back(v(0,1, 6,1, 0,0,  7,1,0, 0,1,0, 1,16'h0040,2));
        vecs.push_back(v(0,1, 6,1, 0,0,  7,1,0, 0,0,0, 1,16'h0040,2));
        vecs.push_back(v(0,1, 6,1, 0,0,  7,1,0, 0,0,0, 1,16'h0040,3));
        vecs.push_back(v(0,1, 6,1, 0,0,  7,1,0, 0,0,0, 0,16'h0000,4));
        vecs.push_back(v(0,1, 0,0, 0,0,  2,1,2, 0,0,0, 0,16'h0000,4));
        vecs.push_back(v(0,1, 0,0, 0,0,  2,1,0, 0,0,0, 1,16'h0004,4));
        vecs.push_back(v(0,1, 0,0, 0,0,  2,1,0, 0,0,0, 1,16'h0004,5));
        vecs.push_back(v(0,1, 0,0, 0,0,  2,1,0, 0,0,0, 1,16'h0004,6));
        vecs.push_back(v(0,1, 0,0, 0,0,  2,1,0, 0,0,0, 0,16'h0000,7));
        vecs.push_back(v(0,1, 0,0, 0,0,  8,1,1, 0,0,0, 0,16'h0000,7));
        vecs.push_back(v(0,1, 0,0, 0,0,  8,1,2, 0,0,0, 0,16'h0100,7));
        vecs.push_back(v(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,16'h0100,7));
        vecs.push_back(v(0,1, 0,1, 8,1,  9,1,0, 0,0,0, 1,16'h0100,7));
        vecs.push_back(v(0,1, 0,1, 8,1,  9,1,0, 0,0,0, 1,16'h0100,8));
        vecs.push_back(v(0,1, 0,1, 8,1,  9,1,0, 0,0,0, 0,16'h0000,9));
        vecs.push_back(v(0,1, 0,0, 0,0,  0,1,1, 0,0,0, 0,16'h0000,9));
        vecs.push_back(v(0,1, 0,1, 0,1,  3,1,0, 0,0,0, 0,16'h0000,9));
        vecs.push_back(v(0,1, 0,0, 0,0, 10,1,2, 0,0,0, 0,16'h0000,9));
        vecs.push_back(v(0,1,10,0,10,0, 11,1,0, 0,0,0, 0,16'h0400,9));
        vecs.push_back(v(0,1,10,1, 0,0, 12,1,2, 1,0,0, 0,16'h0400,9));
        vecs.push_back(v(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,16'h0400,9));
        vecs.push_back(v(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,16'h0000,9));
        vecs.push_back(v(0,0, 0,0, 0,0,  0,0,0, 0,0,1, 0,16'h0000,9));
        vecs.push_back(v(0,0, 0,0, 0,0,  0,0,0, 0,0,0, 0,16'h0000,0));
        vecs.push_back(v(0,1, 0,0, 0,0, 13,1,2, 0,0,0, 0,16'h0000,0));
        vecs.push_back(v(0,1,13,1, 0,0, 14,1,0, 0,0,1, 1,16'h2000,0));
        vecs.push_back(v(0,1,13,1, 0,0, 14,1,0, 0,0,0, 1,16'h2000,0));
        vecs.push_back(v(1,1,13,1, 0,0, 14,1,0, 0,0,0, 1,16'h2000,1));
        vecs.push_back(v(0,1,13,1, 0,0, 14,1,0, 0,0,0, 0,16'h0000,0));

        idle = v(0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0,16'h0000,0);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) apply(i, vecs[i]);

        // Self-dependent long op: three interlock cycles per issue until the counter saturates
        mcnt = 0; sc_model = 0; n_st = 0; iters = 0;
        t = v(0,1, 1,1, 0,0, 1,1,2, 0,0,0, 0,16'h0000,0);
        while (n_st < (1 << PW) + 5 && iters < 2000) begin
            @(negedge clk);
            drive(t);
            #1;
            chk("sat_stall", iters, 32'(stall), 32'(mcnt != 0));
            if (mcnt != 0) begin
                n_st++;
                if (sc_model < (1 << PW) - 1) sc_model++;
                mcnt--;
            end else begin
                mcnt = 3;
            end
            iters++;
        end
        if (iters >= 2000) chk("sat_budget", iters, 32'(n_st), 32'((1 << PW) + 5));
        @(negedge clk);
        drive(idle);
        #1;
        chk("sat_value", 0, 32'(stall_cycles), 32'(sc_model));
        chk("sat_all_ones", 0, 32'(stall_cycles), 32'((1 << PW) - 1));
        @(negedge clk);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        #1;
        chk("perf_clr", 0, 32'(stall_cycles), 32'(0));

        // Reset in the middle of a long countdown
        repeat (4) @(negedge clk);
        drive(v(0,1, 0,0, 0,0, 5,1,2, 0,0,0, 0,16'h0000,0));
        @(negedge clk);
        drive(v(0,1, 5,1, 0,0, 6,1,0, 0,0,0, 0,16'h0000,0));
        rst = 1'b1;
        #1;
        chk("pre_rst_stall", 0, 32'(stall), 32'(1));
        chk("pre_rst_busy", 0, 32'(busy_mask), 32'(16'h0020));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_stall", 0, 32'(stall), 32'(0));
        chk("post_rst_busy", 0, 32'(busy_mask), 32'(0));
        chk("post_rst_cycles", 0, 32'(stall_cycles), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register scoreboard and interlock unit for the pipelined core, sitting beside the decode stage and feeding the pipeline stall/bubble logic. It tracks every in-flight register write with a per-register countdown of cycles until the result is forwardable. It raises `stall` for RAW hazards (general load-use and multi-cycle latency classes) and for WAW hazards between latency classes. It freezes on data-memory stalls and counts interlock cycles for performance analysis.

## Interface
- `NUM_REGS`, 16: architectural registers; register 0 is hard-wired zero and never tracked.
- `REG_W`, $clog2(NUM_REGS): register specifier width.
- `ALU_LAT`, 0: cycles after issue until an ALU result is forwardable.
- `LOAD_LAT`, 1: cycles after issue until load data is forwardable.
- `LONG_LAT`, 3: cycles for the long class (multi-cycle units).
- `PERF_W`, 16: stall-cycle counter width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_rs`, `id_rt`  in  REG_W  source specifiers.
- `id_rs_used`, `id_rt_used`  in  1  source is actually read.
- `id_rd`  in  REG_W  destination specifier.
- `id_rd_we`  in  1  instruction writes `id_rd`.
- `id_lat_cls`  in  2  latency class: 0 = ALU, 1 = load, 2 or 3 = long.
- `flush`  in  1  kill the decode-slot instruction this cycle.
- `mem_stall`  in  1  data memory not ready; whole pipeline frozen.
- `perf_clr`  in  1  clear stall counter.
- `stall`  out  1  hold the decode slot and insert a bubble.
- `busy_mask`  out  NUM_REGS  bit r set when cnt[r] != 0.
- `stall_cycles`  out  PERF_W  saturating count of interlock cycles.

## Operation
- State: cnt[r] for r = 1..NUM_REGS-1. Width is $clog2(max latency + 1). cnt[0] is constant 0.
- new_lat = ALU_LAT, LOAD_LAT, or LONG_LAT, selected by `id_lat_cls`.
- RAW hazard when either condition holds:
  - `id_rs_used` and `id_rs` != 0 and cnt[id_rs] != 0.
  - `id_rt_used` and `id_rt` != 0 and cnt[id_rt] != 0.
- WAW hazard: `id_rd_we` and `id_rd` != 0 and cnt[id_rd] > new_lat.
- `stall` = `id_valid` & ~`flush` & (RAW | WAW). It is combinational from registered state and the ID inputs.
- issue = `id_valid` & ~`flush` & ~`mem_stall` & ~`stall`.
- Each cycle with ~`mem_stall`, every nonzero cnt decrements by 1.
- On issue with `id_rd_we` and `id_rd` != 0, cnt[id_rd] loads new_lat. The load overrides that register's decrement in the same cycle. A new_lat of 0 leaves it 0.
- When `mem_stall` is high, all cnt hold and no issue occurs. `stall` is still evaluated.
- `flush` only suppresses issue. Older in-flight entries are untouched.
- Hazard check uses pre-update state, so an instruction reading its own destination compares against the older writer only.
- `stall_cycles` increments when `stall` & ~`mem_stall`, and saturates at all-ones. `perf_clr` clears it to 0 and takes priority over increment.
- Reset: all cnt = 0, `busy_mask` = 0, `stall_cycles` = 0. With all cnt = 0, `stall` = 0 regardless of inputs.

## Timing
- Load issued at cycle T with LOAD_LAT = 1:
  - cnt = 1 at T+1, so a dependent instruction in ID stalls at T+1.
  - cnt = 0 at T+2 and the dependent issues. Exactly one bubble.
- With ALU_LAT = 0, back-to-back ALU dependences never stall; forwarding covers them.
- A long-class write with LONG_LAT = 3 stalls a dependent for 3 cycles. Each `mem_stall` cycle extends this by one.
- Issue to the same rd while its cnt is nonzero and new_lat >= cnt: cnt reloads with new_lat with no stall. The younger writer wins.
- `rst` high mid-operation clears all state on the next edge. `stall` drops in that cycle's combinational output after the edge.
- No internal pipelining. Latency from any input to `stall` is 0 cycles; latency to scoreboard state is 1 cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams (ADD through HLT, 4-bit);
  - latency-class encodings LAT_ALU, LAT_LOAD, LAT_LONG;
  - default latency constants.
- Sub-module `sb_counter` is one per-register down-counter with `load`, `load_val`, `hold`, `busy`. It is generated for indices 1..NUM_REGS-1.
- Top level contains the hazard comparators, issue logic, and perf counter.

## Test plan
- Load R3 (cls 1) at T, then ADD R4,R3,R5 at T+1 -> `stall` = 1 at T+1 only, issue at T+2, `stall_cycles` = 1.
- Long write R6 (cls 2) at T, then a consumer of R6 -> `stall` high at T+1..T+3, issue at T+4. Adding `mem_stall` at T+2 -> issue at T+5 and `stall_cycles` still = 3.
- Long write R2 at T, then ALU write R2 (cls 0) at T+1 -> WAW `stall` until cnt[R2] = 0. `busy_mask[2]` clears at T+4.
- Load R0, then a consumer of R0 -> no stall and `busy_mask` = 0.
- Hazarding instruction with `flush` = 1 -> `stall` = 0, no scoreboard update. Existing cnt continue decrementing.
- 2^PERF_W + 5 forced stall cycles -> `stall_cycles` = all-ones. `perf_clr` -> 0. `rst` mid-countdown -> all cnt = 0 and `stall` = 0 next cycle.
